// File: rtl/crono_pkg.sv
// Shared types, BCD limits and BCD helper functions for the crono_bcd countdown timer.
package crono_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    RING
  } state_t;

  localparam logic [7:0] SS_MAX  = 8'h59;
  localparam logic [7:0] MM_MAX  = 8'h59;
  localparam logic [7:0] HH_MAX  = 8'h23;
  localparam logic [3:0] NIB_MAX = 4'd9;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } bcd_time_t;

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= NIB_MAX) && (v[3:0] <= NIB_MAX) && (v <= max);
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] wrap);
    if (v == 8'h00)
      return wrap;
    else if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, NIB_MAX};
    else
      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Borrow ripples ss -> mm -> hh; hh never wraps because a zero count never runs.
  function automatic bcd_time_t time_dec(input bcd_time_t t);
    bcd_time_t r;
    r    = t;
    r.ss = bcd_dec(t.ss, SS_MAX);
    if (t.ss == 8'h00) begin
      r.mm = bcd_dec(t.mm, MM_MAX);
      if (t.mm == 8'h00)
        r.hh = bcd_dec(t.hh, HH_MAX);
    end
    return r;
  endfunction

endpackage

// File: rtl/crono_bcd_if.sv
// Control/preset/display bundle of the crono_bcd countdown timer.
interface crono_bcd_if;
  logic       load;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic [7:0] set_ss;
  logic       start;
  logic       stop;
  logic       ack;
  logic [7:0] seg_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hor_bcd;
  logic       ring;
  logic       running;
  logic       load_err;

  modport master (
    output load, set_hh, set_mm, set_ss, start, stop, ack,
    input  seg_bcd, min_bcd, hor_bcd, ring, running, load_err
  );

  modport slave (
    input  load, set_hh, set_mm, set_ss, start, stop, ack,
    output seg_bcd, min_bcd, hor_bcd, ring, running, load_err
  );
endinterface

// File: rtl/crono_prescaler.sv
// One-second prescaler: tick is high on the last cycle of each TICKS_PER_SEC window while enabled.
module crono_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (en)
      cnt <= tick ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/crono_bcd.sv
// BCD hh:mm:ss countdown timer with IDLE/RUN/PAUSE/RING control.
// Optional CRONO_RING_TIMEOUT_EN: RING returns to IDLE by itself after RING_SECS seconds.
module crono_bcd
  import crono_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned RING_SECS     = 10
) (
  input  logic        clk,
  input  logic        reset,
  crono_bcd_if.slave  bus
);

  if (TICKS_PER_SEC == 0 || RING_SECS == 0) begin : g_bad_cfg
    $error("crono_bcd: TICKS_PER_SEC and RING_SECS must be nonzero");
  end

  state_t    state;
  bcd_time_t cnt;
  bcd_time_t cnt_next;
  logic      tick;
  logic      run_en;
  logic      go;
  logic      load_ok;
  logic      ring_r;
  logic      running_r;
  logic      load_err_r;

  // A start sharing its cycle with a load is dropped so a freshly loaded zero can never run.
  always_comb begin
    run_en   = (state == RUN);
    cnt_next = time_dec(cnt);
    load_ok  = bcd_ok(bus.set_hh, HH_MAX) && bcd_ok(bus.set_mm, MM_MAX) &&
               bcd_ok(bus.set_ss, SS_MAX);
    go       = ((state == IDLE) || (state == PAUSE)) && bus.start && !bus.stop &&
               !bus.load && (cnt != '0);
  end

  crono_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (go),
    .en    (run_en),
    .tick  (tick)
  );

`ifdef CRONO_RING_TIMEOUT_EN
  localparam int unsigned RING_CYC = RING_SECS * TICKS_PER_SEC;
  localparam int unsigned RW       = (RING_CYC > 1) ? $clog2(RING_CYC) : 1;
  logic [RW-1:0] ring_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ring_r     <= 1'b0;
      running_r  <= 1'b0;
      load_err_r <= 1'b0;
`ifdef CRONO_RING_TIMEOUT_EN
      ring_cnt   <= '0;
`endif
    end else begin
      load_err_r <= 1'b0;
      case (state)
        IDLE, PAUSE: begin
          if (bus.load) begin
            if (load_ok)
              cnt <= '{hh: bus.set_hh, mm: bus.set_mm, ss: bus.set_ss};
            else
              load_err_r <= 1'b1;
          end else if (go) begin
            state     <= RUN;
            running_r <= 1'b1;
          end
        end
        RUN: begin
          // Expiry outranks a simultaneous stop.
          if (tick) begin
            cnt <= cnt_next;
            if (cnt_next == '0) begin
              state     <= RING;
              ring_r    <= 1'b1;
              running_r <= 1'b0;
`ifdef CRONO_RING_TIMEOUT_EN
              ring_cnt  <= '0;
`endif
            end else if (bus.stop) begin
              state     <= PAUSE;
              running_r <= 1'b0;
            end
          end else if (bus.stop) begin
            state     <= PAUSE;
            running_r <= 1'b0;
          end
        end
        RING: begin
`ifdef CRONO_RING_TIMEOUT_EN
          ring_cnt <= ring_cnt + RW'(1);
          if (bus.ack || (ring_cnt == RW'(RING_CYC - 1))) begin
            state  <= IDLE;
            ring_r <= 1'b0;
          end
`else
          if (bus.ack) begin
            state  <= IDLE;
            ring_r <= 1'b0;
          end
`endif
        end
        default: begin
          state     <= IDLE;
          ring_r    <= 1'b0;
          running_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.seg_bcd  = cnt.ss;
  assign bus.min_bcd  = cnt.mm;
  assign bus.hor_bcd  = cnt.hh;
  assign bus.ring     = ring_r;
  assign bus.running  = running_r;
  assign bus.load_err = load_err_r;

endmodule

// File: tb/tb_crono_bcd.sv
// Directed bench for crono_bcd at TICKS_PER_SEC=4, RING_SECS=2; honours CRONO_RING_TIMEOUT_EN.
module tb_crono_bcd;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  crono_bcd_if bus ();

  crono_bcd #(
    .TICKS_PER_SEC(4),
    .RING_SECS    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  hh;
    logic [7:0]  mm;
    logic [7:0]  ss;
    logic        err;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] count_now();
    return {bus.hor_bcd, bus.min_bcd, bus.seg_bcd};
  endfunction

  task automatic do_load(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
    bus.set_hh = hh;
    bus.set_mm = mm;
    bus.set_ss = ss;
    bus.load   = 1'b1;
    step();
    bus.load   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h12, 8'h34, 8'h56, 1'b0, 24'h123456};
    vecs[1] = '{8'h00, 8'h00, 8'h5A, 1'b1, 24'h123456};
    vecs[2] = '{8'h24, 8'h00, 8'h00, 1'b1, 24'h123456};
    vecs[3] = '{8'h23, 8'h59, 8'h59, 1'b0, 24'h235959};
    vecs[4] = '{8'h00, 8'h60, 8'h00, 1'b1, 24'h235959};
    vecs[5] = '{8'h1F, 8'h00, 8'h00, 1'b1, 24'h235959};
    vecs[6] = '{8'h09, 8'h0A, 8'h00, 1'b1, 24'h235959};
    vecs[7] = '{8'h00, 8'h00, 8'h00, 1'b0, 24'h000000};
    vecs[8] = '{8'h00, 8'h00, 8'h03, 1'b0, 24'h000003};

    bus.load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.ack = 1'b0;
    bus.set_hh = '0; bus.set_mm = '0; bus.set_ss = '0;
    reset = 1'b1;
    step(2);
    check("reset_count", 32'(count_now()), 32'h0);
    check("reset_flags", {29'd0, bus.ring, bus.running, bus.load_err}, 32'd0);
    reset = 1'b0;
    step();

    // Load table in IDLE: valid loads land next cycle, rejected ones pulse load_err once.
    for (int i = 0; i < 9; i++) begin
      do_load(vecs[i].hh, vecs[i].mm, vecs[i].ss);
      check($sformatf("load%0d_count", i), 32'(count_now()), 32'(vecs[i].exp));
      check($sformatf("load%0d_err", i), 32'(bus.load_err), 32'(vecs[i].err));
      step();
      check($sformatf("load%0d_err_drop", i), 32'(bus.load_err), 32'd0);
    end

    // 00:00:03 countdown to expiry.
    pulse_start();
    check("a_running", 32'(bus.running), 32'd1);
    step(3);
    check("a_seg_hold3", 32'(bus.seg_bcd), 32'h03);
    step();
    check("a_seg_4", 32'(bus.seg_bcd), 32'h02);
    step(4);
    check("a_seg_8", 32'(bus.seg_bcd), 32'h01);
    step(4);
    check("a_seg_12", 32'(bus.seg_bcd), 32'h00);
    check("a_ring_12", 32'(bus.ring), 32'd1);
    check("a_running_12", 32'(bus.running), 32'd0);
    step();
    check("a_ring_hold", 32'(bus.ring), 32'd1);
    do_load(8'h00, 8'h00, 8'h09);
    check("ring_load_count", 32'(count_now()), 32'h0);
    check("ring_load_err", 32'(bus.load_err), 32'd0);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    check("ack_ring", 32'(bus.ring), 32'd0);
    check("ack_running", 32'(bus.running), 32'd0);

    // 01:00:00 borrow across all fields.
    do_load(8'h01, 8'h00, 8'h00);
    check("b_load", 32'(count_now()), 32'h010000);
    pulse_start();
    step(3);
    check("b_hold", 32'(count_now()), 32'h010000);
    step();
    check("b_borrow", 32'(count_now()), 32'h005959);
    do_load(8'h00, 8'h00, 8'h07);
    check("run_load_count", 32'(count_now()), 32'h005959);
    check("run_load_err", 32'(bus.load_err), 32'd0);

    // stop+start together pauses; resume decrements exactly 4 cycles later.
    bus.stop = 1'b1; bus.start = 1'b1;
    step();
    bus.stop = 1'b0; bus.start = 1'b0;
    check("c_paused", 32'(bus.running), 32'd0);
    step(20);
    check("c_frozen", 32'(count_now()), 32'h005959);
    check("c_frozen_run", 32'(bus.running), 32'd0);
    pulse_start();
    check("c_resume", 32'(bus.running), 32'd1);
    step(3);
    check("c_resume_hold", 32'(count_now()), 32'h005959);
    step();
    check("c_resume_dec", 32'(count_now()), 32'h005958);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("c_stop", 32'(bus.running), 32'd0);
    do_load(8'h00, 8'h10, 8'h05);
    check("pause_load", 32'(count_now()), 32'h001005);

    // Reset mid-RUN overrides load/start in the same cycle.
    pulse_start();
    step(2);
    check("d_running", 32'(bus.running), 32'd1);
    check("d_count", 32'(count_now()), 32'h001005);
    reset = 1'b1; bus.load = 1'b1; bus.start = 1'b1;
    bus.set_hh = 8'h12; bus.set_mm = 8'h00; bus.set_ss = 8'h00;
    step();
    reset = 1'b0; bus.load = 1'b0; bus.start = 1'b0;
    check("d_rst_count", 32'(count_now()), 32'h0);
    check("d_rst_flags", {29'd0, bus.ring, bus.running, bus.load_err}, 32'd0);
    pulse_start();
    check("d_zero_start", 32'(bus.running), 32'd0);
    step(5);
    check("d_zero_idle", 32'(bus.running), 32'd0);
    check("d_zero_ring", 32'(bus.ring), 32'd0);

    // Start on the expiring tick has no effect; then ring hold/timeout.
    do_load(8'h00, 8'h00, 8'h01);
    pulse_start();
    step(3);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("e_expire_count", 32'(count_now()), 32'h0);
    check("e_expire_ring", 32'(bus.ring), 32'd1);
    check("e_expire_run", 32'(bus.running), 32'd0);
    step();
    check("e_ring_r1", 32'(bus.ring), 32'd1);
`ifdef CRONO_RING_TIMEOUT_EN
    step(6);
    check("timeout_r7", 32'(bus.ring), 32'd1);
    step();
    check("timeout_r8", 32'(bus.ring), 32'd0);
    check("timeout_run", 32'(bus.running), 32'd0);
`else
    step(100);
    check("hold_ring", 32'(bus.ring), 32'd1);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    check("hold_ack", 32'(bus.ring), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
